sine_lut_synth: RTL and testbench

//  Downstream stage of the DDS phase accumulator. Converts each 24-bit phase word into a signed sine sample.

---
 rtl/sine_lut_synth.sv | 100 ++++++++++
 tb/tb_sine_lut_synth.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sine_lut_synth.sv
// DDS sine stage: 24-bit phase word -> signed sine sample through a folded
// quarter-wave ROM, three pipeline stages, and a valid/ready output register.
module sine_lut_synth #(
    parameter int PHASE_WIDTH    = 24,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int SAMPLE_WIDTH   = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PHASE_WIDTH-1:0]  phase_in,
    input  logic                    phase_valid,
    output logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    input  logic                    overrun_clear
);

    localparam int STAGES = 1;
    localparam int MAG_W  = SAMPLE_WIDTH - 1;
    localparam int DEPTH  = 1 << LUT_ADDR_WIDTH;

    typedef logic [DEPTH-1:0][MAG_W-1:0] rom_t;

    // Half-LSB phase offset keeps the table free of zero and of a doubled peak,
    // so mirroring by bit inversion is exact.
    function automatic rom_t build_rom();
        rom_t t;
        real  pi;
        real  amp;
        pi  = 3.14159265358979323846;
        amp = real'((1 << MAG_W) - 1);
        for (int i = 0; i < DEPTH; i++)
            t[i] = MAG_W'($rtoi(amp * $sin(pi / 2.0 * (real'(i) + 0.5) / real'(DEPTH)) + 0.5));
        return t;
    endfunction

    localparam rom_t ROM = build_rom();

    logic [1:0]                quad;
    logic [LUT_ADDR_WIDTH-1:0] idx;
    logic                      unused_phase_lsbs;

    assign quad              = phase_in[PHASE_WIDTH-1 -: 2];
    assign idx               = phase_in[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    assign unused_phase_lsbs = ^phase_in[PHASE_WIDTH-LUT_ADDR_WIDTH-3:0];

    logic [STAGES:0]           vld_pipe;
    logic [LUT_ADDR_WIDTH-1:0] addr_q;
    logic                      neg0_q;
    logic [MAG_W-1:0]          mag_q;
    logic                      neg1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            addr_q   <= '0;
            neg0_q   <= 1'b0;
            mag_q    <= '0;
            neg1_q   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], phase_valid};
            if (phase_valid) begin
                addr_q <= quad[0] ? ~idx : idx;
                neg0_q <= quad[1];
            end
            mag_q  <= ROM[addr_q];
            neg1_q <= neg0_q;
        end
    end

    logic [SAMPLE_WIDTH-1:0] mag_ext;
    logic [SAMPLE_WIDTH-1:0] result;
    logic                    new_res;

    assign mag_ext = {1'b0, mag_q};
    assign result  = neg1_q ? -mag_ext : mag_ext;
    assign new_res = vld_pipe[STAGES];

    // Freshest sample always wins; overwriting an unconsumed one flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (new_res) begin
                sample       <= result;
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (new_res && sample_valid && !sample_ready)
                overrun <= 1'b1;
            else if (overrun_clear)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sine_lut_synth.sv
// Bench for sine_lut_synth: fixed vector table, directed back-pressure/reset
// sequences, a full-period sweep and random phases against a real-valued model.
module tb_sine_lut_synth;

    logic               clk;
    logic               rst_n;
    logic [23:0]        phase_in;
    logic               phase_valid;
    logic signed [11:0] sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;
    logic               overrun_clear;

    int vectors;
    int miscompares;

    sine_lut_synth dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phase_in     (phase_in),
        .phase_valid  (phase_valid),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clear(overrun_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] phase;
        int          exp_sample;
    } vec_t;

    vec_t vecs[8];
    int   sweep[1024];
    logic hv[300];
    logic [23:0] hp[300];

    // Whole-circle view: a 10-bit phase bucket sampled at its centre.
    function automatic int model(input logic [23:0] p);
        real pi, v, a;
        int  m;
        pi = 3.14159265358979323846;
        v  = 2047.0 * $sin(2.0 * pi * (real'(p >> 14) + 0.5) / 1024.0);
        a  = (v < 0.0) ? -v : v;
        m  = $rtoi(a + 0.5);
        return (v < 0.0) ? -m : m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [23:0] p, input logic r, input logic c);
        phase_valid   = v;
        phase_in      = p;
        sample_ready  = r;
        overrun_clear = c;
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0; phase_in = '0; phase_valid = 1'b0;
        sample_ready = 1'b1; overrun_clear = 1'b0;
        vecs[0] = '{24'h000000,     6};
        vecs[1] = '{24'h400000,  2047};
        vecs[2] = '{24'h800000,    -6};
        vecs[3] = '{24'hC00000, -2047};
        vecs[4] = '{24'hFFFFFF,    -6};
        vecs[5] = '{24'h3FFFFF,  2047};
        vecs[6] = '{24'h7FFFFF,     6};
        vecs[7] = '{24'hBFFFFF, -2047};

        repeat (2) @(negedge clk);
        chk("reset sample", sample, 0);
        chk("reset valid", sample_valid, 0);
        chk("reset overrun", overrun, 0);
        rst_n = 1'b1;
        step(0, 0, 1, 0);

        // Single pulses: result visible exactly three cycles later for one cycle.
        foreach (vecs[i]) begin
            step(1, vecs[i].phase, 1, 0);
            step(0, 0, 1, 0);
            chk("latency early", sample_valid, 0);
            step(0, 0, 1, 0);
            chk("table valid", sample_valid, 1);
            chk("table sample", sample, vecs[i].exp_sample);
            step(0, 0, 1, 0);
            chk("table valid drop", sample_valid, 0);
        end

        // Full period at full rate.
        for (int k = 0; k < 1026; k++) begin
            step(k < 1024, 24'(k * 24'h004000), 1, 0);
            if (k >= 2) begin
                chk("sweep valid", sample_valid, 1);
                sweep[k-2] = sample;
                chk("sweep model", sample, model(24'((k - 2) * 24'h004000)));
            end
        end
        step(0, 0, 1, 0);
        chk("sweep drained", sample_valid, 0);
        for (int k = 0; k < 512; k++)
            chk("half-wave antisym", sweep[k], -sweep[k+512]);
        for (int k = 0; k < 256; k++)
            chk("quarter mirror", sweep[k], sweep[511-k]);

        // Overwrite while stalled, then clear; then set and clear together.
        step(1, 24'h000000, 0, 0);
        step(1, 24'h400000, 0, 0);
        step(0, 0, 0, 0);
        chk("ovr first load", sample, 6);
        chk("ovr no flag yet", overrun, 0);
        step(0, 0, 0, 0);
        chk("ovr sample", sample, 2047);
        chk("ovr valid", sample_valid, 1);
        chk("ovr flag", overrun, 1);
        step(0, 0, 0, 1);
        chk("ovr cleared", overrun, 0);
        step(1, 24'h800000, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("set beats clear", overrun, 1);
        chk("set beats clear sample", sample, -6);
        step(0, 0, 1, 1);
        chk("drain valid", sample_valid, 0);
        chk("drain clear", overrun, 0);

        // Consumer accepts in the same cycle a new result lands.
        step(1, 24'h000000, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pending valid", sample_valid, 1);
        step(1, 24'h800000, 0, 0);
        step(0, 0, 0, 0);
        chk("pending held", sample, 6);
        step(0, 0, 1, 0);
        chk("accept+new sample", sample, -6);
        chk("accept+new valid", sample_valid, 1);
        chk("accept+new overrun", overrun, 0);
        step(0, 0, 1, 0);
        chk("accept+new drain", sample_valid, 0);

        // Random phases and strobes, consumer always ready.
        for (int j = 0; j < 300; j++) begin
            hv[j] = 1'($urandom_range(0, 1));
            hp[j] = 24'($urandom);
            step(hv[j], hp[j], 1, 0);
            if (j >= 2) begin
                chk("rand valid", sample_valid, hv[j-2]);
                if (hv[j-2])
                    chk("rand sample", sample, model(hp[j-2]));
            end
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Reset mid-pipeline with overrun set and a non-zero sample held.
        step(1, 24'h000000, 0, 0);
        step(1, 24'h400000, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre-reset overrun", overrun, 1);
        step(1, 24'hC00000, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("async rst sample", sample, 0);
        chk("async rst valid", sample_valid, 0);
        chk("async rst overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0);
            chk("post-reset quiet", sample_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
